bus_rr_arbiter: RTL and testbench

Round-robin bus arbiter and master multiplexer, directly downstream of the CPU bus interfaces and other bus masters. Takes up to four active-low bus requests, grants exactly one master at a time and holds the grant until that master releases its request. Routes the owner's address, strobe, read/write and write data onto the shared slave-side bus. Optionally forces the grant away from a master that holds it too long.

---
 rtl/bus_rr_arbiter_pkg.sv | 42 ++++
 rtl/bus_rr_arbiter_if.sv | 39 +++
 rtl/bus_arb_rr_picker.sv | 27 ++
 rtl/bus_rr_arbiter.sv | 116 +++++++++++
 tb/tb_bus_rr_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_rr_arbiter_pkg.sv
// rtl/bus_rr_arbiter_pkg.sv - shared bus constants, types and grant decode helper
package bus_rr_arbiter_pkg;

    localparam int BUS_MASTER_CH      = 4;
    localparam int BUS_MASTER_INDEX_W = 2;

    typedef logic [BUS_MASTER_INDEX_W-1:0] bus_master_idx_t;

    localparam bus_master_idx_t BUS_MASTER_0 = 2'd0;
    localparam bus_master_idx_t BUS_MASTER_1 = 2'd1;
    localparam bus_master_idx_t BUS_MASTER_2 = 2'd2;
    localparam bus_master_idx_t BUS_MASTER_3 = 2'd3;

    // Active-low enable levels and rw encoding shared with the CPU bus interfaces.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    typedef logic [WORD_ADDR_W-1:0] word_addr_t;
    typedef logic [WORD_DATA_W-1:0] word_data_t;

    // One master's slave-side command bundle.
    typedef struct packed {
        word_addr_t addr;
        logic       as_n;
        logic       rw;
        word_data_t wr_data;
    } bus_cmd_t;

    // Active-low one-cold grant vector for the given owner.
    function automatic logic [BUS_MASTER_CH-1:0] grant_decode(input bus_master_idx_t idx);
        logic [BUS_MASTER_CH-1:0] onehot;
        onehot = '0;
        onehot[idx] = 1'b1;
        return ~onehot;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// rtl/bus_rr_arbiter_if.sv - master-side request/command signals and shared slave bus
interface bus_rr_arbiter_if;
    import bus_rr_arbiter_pkg::*;

    logic       m0_req_n, m1_req_n, m2_req_n, m3_req_n;
    word_addr_t m0_addr, m1_addr, m2_addr, m3_addr;
    logic       m0_as_n, m1_as_n, m2_as_n, m3_as_n;
    logic       m0_rw, m1_rw, m2_rw, m3_rw;
    word_data_t m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data;
    logic       m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n;

    word_addr_t s_addr;
    logic       s_as_n;
    logic       s_rw;
    word_data_t s_wr_data;

    // Bus masters: drive requests and commands, observe grants and the shared bus.
    modport master (
        output m0_req_n, m1_req_n, m2_req_n, m3_req_n,
        output m0_addr, m1_addr, m2_addr, m3_addr,
        output m0_as_n, m1_as_n, m2_as_n, m3_as_n,
        output m0_rw, m1_rw, m2_rw, m3_rw,
        output m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data,
        input  m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n,
        input  s_addr, s_as_n, s_rw, s_wr_data
    );

    // Arbiter: receives requests and commands, drives grants and the shared bus.
    modport slave (
        input  m0_req_n, m1_req_n, m2_req_n, m3_req_n,
        input  m0_addr, m1_addr, m2_addr, m3_addr,
        input  m0_as_n, m1_as_n, m2_as_n, m3_as_n,
        input  m0_rw, m1_rw, m2_rw, m3_rw,
        input  m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data,
        output m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n,
        output s_addr, s_as_n, s_rw, s_wr_data
    );

endinterface

// File: rtl/bus_arb_rr_picker.sv
// rtl/bus_arb_rr_picker.sv - rotating-priority search for the next bus owner
module bus_arb_rr_picker
    import bus_rr_arbiter_pkg::*;
(
    input  logic [BUS_MASTER_CH-1:0] req,
    input  bus_master_idx_t          owner,
    output bus_master_idx_t          next_owner,
    output logic                     found
);

    bus_master_idx_t cand;

    // Scan owner+1, owner+2, owner+3; the owner itself is never a candidate.
    always_comb begin
        next_owner = owner;
        found      = 1'b0;
        cand       = owner;
        for (int k = 1; k < BUS_MASTER_CH; k++) begin
            cand = owner + bus_master_idx_t'(k);
            if (!found && req[cand]) begin
                found      = 1'b1;
                next_owner = cand;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - parked round-robin arbiter and slave mux, optional timeout via BUS_ARB_TIMEOUT_EN
module bus_rr_arbiter
    import bus_rr_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
)
(
    input  logic             clk,
    input  logic             reset,
    bus_rr_arbiter_if.slave  bus,
    output bus_master_idx_t  owner,
    output logic             timeout_err,
    output bus_master_idx_t  timeout_id
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..65535");
    end

    logic [BUS_MASTER_CH-1:0] req;
    logic [BUS_MASTER_CH-1:0] grnt_n;
    bus_cmd_t                 cmd [BUS_MASTER_CH];
    bus_cmd_t                 sel;
    bus_master_idx_t          owner_nxt;
    bus_master_idx_t          pick_owner;
    logic                     pick_found;
    logic                     owner_req;
    logic                     timeout_fire;

    assign req = {bus.m3_req_n == ENABLE_, bus.m2_req_n == ENABLE_,
                  bus.m1_req_n == ENABLE_, bus.m0_req_n == ENABLE_};

    assign cmd[0] = {bus.m0_addr, bus.m0_as_n, bus.m0_rw, bus.m0_wr_data};
    assign cmd[1] = {bus.m1_addr, bus.m1_as_n, bus.m1_rw, bus.m1_wr_data};
    assign cmd[2] = {bus.m2_addr, bus.m2_as_n, bus.m2_rw, bus.m2_wr_data};
    assign cmd[3] = {bus.m3_addr, bus.m3_as_n, bus.m3_rw, bus.m3_wr_data};

    assign owner_req = req[owner];

    bus_arb_rr_picker u_picker (
        .req        (req),
        .owner      (owner),
        .next_owner (pick_owner),
        .found      (pick_found)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] hold_cnt;

    // Force rotation only when the owner has held long enough and someone else is waiting.
    assign timeout_fire = owner_req && pick_found && (hold_cnt == TIMEOUT_LAST);

    // Count consecutive requested ownership cycles; saturate when nobody else is waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if ((owner_nxt != owner) || !owner_req) begin
            hold_cnt <= '0;
        end else if (hold_cnt != TIMEOUT_LAST) begin
            hold_cnt <= hold_cnt + 16'd1;
        end
    end

    // One-cycle error pulse and sticky record of the master that was pre-empted.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err <= 1'b0;
            timeout_id  <= BUS_MASTER_0;
        end else begin
            timeout_err <= timeout_fire;
            if (timeout_fire) begin
                timeout_id <= owner;
            end
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign timeout_err  = 1'b0;
    assign timeout_id   = BUS_MASTER_0;
`endif

    // Next owner: keep while requested, otherwise hand over to the first waiting master.
    always_comb begin
        owner_nxt = owner;
        if ((!owner_req || timeout_fire) && pick_found) begin
            owner_nxt = pick_owner;
        end
    end

    // Owner and grant are registered together so the grant never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner  <= BUS_MASTER_0;
            grnt_n <= grant_decode(BUS_MASTER_0);
        end else begin
            owner  <= owner_nxt;
            grnt_n <= grant_decode(owner_nxt);
        end
    end

    // Grants out and slave-side mux steered purely by the current owner.
    always_comb begin
        sel           = cmd[owner];
        bus.m0_grnt_n = grnt_n[0];
        bus.m1_grnt_n = grnt_n[1];
        bus.m2_grnt_n = grnt_n[2];
        bus.m3_grnt_n = grnt_n[3];
        bus.s_addr    = sel.addr;
        bus.s_as_n    = sel.as_n;
        bus.s_rw      = sel.rw;
        bus.s_wr_data = sel.wr_data;
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - scoreboard bench for bus_rr_arbiter
module tb_bus_rr_arbiter;
    import bus_rr_arbiter_pkg::*;

    localparam int TO = 8;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0]  req_n;
    logic [3:0]  as_n;
    logic [3:0]  rw;
    logic [29:0] addr [4];
    logic [31:0] wdata [4];

    bus_master_idx_t owner;
    logic            timeout_err;
    bus_master_idx_t timeout_id;
    logic [3:0]      gr;

    bus_rr_arbiter_if bus ();

    assign bus.m0_req_n = req_n[0];
    assign bus.m1_req_n = req_n[1];
    assign bus.m2_req_n = req_n[2];
    assign bus.m3_req_n = req_n[3];
    assign bus.m0_as_n = as_n[0];
    assign bus.m1_as_n = as_n[1];
    assign bus.m2_as_n = as_n[2];
    assign bus.m3_as_n = as_n[3];
    assign bus.m0_rw = rw[0];
    assign bus.m1_rw = rw[1];
    assign bus.m2_rw = rw[2];
    assign bus.m3_rw = rw[3];
    assign bus.m0_addr = addr[0];
    assign bus.m1_addr = addr[1];
    assign bus.m2_addr = addr[2];
    assign bus.m3_addr = addr[3];
    assign bus.m0_wr_data = wdata[0];
    assign bus.m1_wr_data = wdata[1];
    assign bus.m2_wr_data = wdata[2];
    assign bus.m3_wr_data = wdata[3];
    assign gr = {bus.m3_grnt_n, bus.m2_grnt_n, bus.m1_grnt_n, bus.m0_grnt_n};

    bus_rr_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .owner       (owner),
        .timeout_err (timeout_err),
        .timeout_id  (timeout_id)
    );

    typedef struct {
        int          owner;
        logic [3:0]  grnt_n;
        logic        err;
        int          id;
        logic [29:0] s_addr;
        logic        s_as_n;
        logic        s_rw;
        logic [31:0] s_wr_data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_owner = 0;
    int   m_held = 0;
    int   m_id = 0;
    int   err_seen = 0;
    bit   trace_en = 1'b0;
    int   trace[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: hold while requested, else first requester after the owner in circular order.
    task automatic model_step();
        exp_t e;
        int   nxt;
        int   cand;
        bit   found;
        bit   err;
        cand  = 0;
        found = 1'b0;
        err   = 1'b0;
        if (reset) begin
            nxt    = 0;
            m_held = 0;
            m_id   = 0;
        end else begin
            for (int k = 1; k < 4; k++) begin
                if (!found && req_n[(m_owner + k) % 4] == 1'b0) begin
                    found = 1'b1;
                    cand  = (m_owner + k) % 4;
                end
            end
            nxt = m_owner;
            if (req_n[m_owner] == 1'b0) begin
                m_held++;
                if (TO_EN && m_held >= TO && found) begin
                    nxt  = cand;
                    err  = 1'b1;
                    m_id = m_owner;
                end
            end else begin
                m_held = 0;
                if (found) nxt = cand;
            end
            if (nxt != m_owner) m_held = 0;
        end
        m_owner     = nxt;
        e.owner     = nxt;
        e.grnt_n    = 4'hF;
        e.grnt_n[nxt] = 1'b0;
        e.err       = err;
        e.id        = m_id;
        e.s_addr    = addr[nxt];
        e.s_as_n    = as_n[nxt];
        e.s_rw      = rw[nxt];
        e.s_wr_data = wdata[nxt];
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic rand_payload();
        for (int i = 0; i < 4; i++) begin
            addr[i]  = 30'($urandom());
            wdata[i] = $urandom();
            rw[i]    = 1'($urandom());
        end
    endtask

    // Monitor: after every edge, pop the expected response and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got empty queue expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("owner", 64'(owner), 64'(e.owner));
                check("grnt_n", 64'(gr), 64'(e.grnt_n));
                check("timeout_err", 64'(timeout_err), 64'(e.err));
                check("timeout_id", 64'(timeout_id), 64'(e.id));
                check("s_addr", 64'(bus.s_addr), 64'(e.s_addr));
                check("s_as_n", 64'(bus.s_as_n), 64'(e.s_as_n));
                check("s_rw", 64'(bus.s_rw), 64'(e.s_rw));
                check("s_wr_data", 64'(bus.s_wr_data), 64'(e.s_wr_data));
            end
            if (timeout_err === 1'b1) err_seen++;
            if (trace_en && (trace.size() == 0 || trace[$] != int'(owner))) trace.push_back(int'(owner));
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        int g;
        int fair_exp [5];
        fair_exp = '{0, 1, 3, 0, 1};
        reset = 1'b1;
        req_n = 4'hF;
        as_n  = 4'hF;
        rand_payload();
        repeat (2) cycle();
        reset = 1'b0;

        // Idle after reset: parked on master 0, s_* follows master 0.
        repeat (10) begin
            rand_payload();
            cycle();
        end

        // Master 2 alone.
        addr[2]  = 30'h0100_0040;
        req_n[2] = 1'b0;
        as_n[2]  = 1'b0;
        cycle();
        check("m2_owner", 64'(owner), 64'd2);
        check("m2_grnt_n", 64'(bus.m2_grnt_n), 64'd0);
        check("m2_s_addr", 64'(bus.s_addr), 64'h0100_0040);
        repeat (3) cycle();
        req_n = 4'hF;
        as_n  = 4'hF;

        // Fairness: 0, 1, 3 each release after 3 granted cycles then re-request.
        reset = 1'b1;
        req_n = 4'b0100;
        cycle();
        reset = 1'b0;
        trace.delete();
        trace_en = 1'b1;
        g = 0;
        repeat (20) begin
            req_n = 4'b0100;
            g++;
            if (g == 3) begin
                req_n[m_owner] = 1'b1;
                g = 0;
            end
            cycle();
        end
        trace_en = 1'b0;
        for (int i = 0; i < 5; i++)
            check($sformatf("fair_order%0d", i), (i < trace.size()) ? 64'(trace[i]) : '1, 64'(fair_exp[i]));

        // Owner 1 releases while 3 requests: handover with no idle cycle.
        reset = 1'b1;
        req_n = 4'hF;
        cycle();
        reset = 1'b0;
        req_n = 4'b1101;
        cycle();
        check("same_cyc_pre", 64'(owner), 64'd1);
        req_n = 4'b0111;
        cycle();
        check("same_cyc_owner", 64'(owner), 64'd3);
        req_n = 4'b0101;
        cycle();
        check("same_cyc_hold", 64'(owner), 64'd3);

        // Long hold by master 0 with master 2 waiting.
        reset = 1'b1;
        req_n = 4'b1110;
        cycle();
        reset = 1'b0;
        err_seen = 0;
        req_n = 4'b1010;
        repeat (12) cycle();
        check("to_pulses", 64'(err_seen), TO_EN ? 64'd1 : 64'd0);
        check("to_owner", 64'(owner), TO_EN ? 64'd2 : 64'd0);
        check("to_id", 64'(timeout_id), 64'd0);

        // Long hold with nobody else waiting: never pre-empted.
        reset = 1'b1;
        req_n = 4'b1110;
        cycle();
        reset = 1'b0;
        err_seen = 0;
        repeat (20) cycle();
        check("sat_pulses", 64'(err_seen), 64'd0);
        check("sat_owner", 64'(owner), 64'd0);

        // Reset while master 3 is mid-access.
        req_n = 4'b0111;
        cycle();
        as_n[3] = 1'b0;
        cycle();
        check("mid_pre_owner", 64'(owner), 64'd3);
        reset = 1'b1;
        cycle();
        check("mid_rst_owner", 64'(owner), 64'd0);
        check("mid_rst_m3_grnt", 64'(bus.m3_grnt_n), 64'd1);
        check("mid_rst_err", 64'(timeout_err), 64'd0);
        reset = 1'b0;
        req_n = 4'hF;
        as_n  = 4'hF;

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rand_payload();
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 7) == 0) req_n[j] = ~req_n[j];
                as_n[j] = 1'($urandom());
            end
            reset = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
